// File: rtl/rr_mux4_collector_if.sv
// Stream bundle for rr_mux4_collector: four valid/ready input lanes plus one tagged output stream.
// The slave modport is the collector's view; master is the upstream/downstream environment.
interface rr_mux4_collector_if #(
    parameter int unsigned DATA_W = 8
);
    logic [3:0]          in_valid;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_last;
    logic [3:0]          in_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_sel;
    logic                out_last;
    logic                out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel,
        output out_last,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/rr_mux4_collector.sv
// 4-to-1 round-robin collector into a single tagged output register.
// Optional packet lock (whole packets from one lane) enabled by macro RR_MUX4_PKT_LOCK_EN.
module rr_mux4_collector #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_mux4_collector_if.slave   bus
);

    logic [1:0]        ptr_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [1:0]        out_sel_q;
    logic              out_last_q;

    logic [3:0]        eligible;
    logic [1:0]        gnt;
    logic              any_eligible;
    logic              load;
    logic              accept;
    logic              gnt_last;

`ifdef RR_MUX4_PKT_LOCK_EN
    typedef enum logic [0:0] {StIdle, StLocked} lock_state_e;

    lock_state_e state_q;
    logic [1:0]  lock_lane_q;

    // While a packet is in flight only its source lane may compete.
    always_comb begin
        eligible = bus.in_valid;
        if (state_q == StLocked) begin
            eligible = bus.in_valid & (4'b0001 << lock_lane_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lock_lane_q <= 2'd0;
        end else if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (!gnt_last) begin
                        state_q     <= StLocked;
                        lock_lane_q <= gnt;
                    end
                end
                StLocked: begin
                    if (gnt_last) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
`else
    always_comb begin
        eligible = bus.in_valid;
    end
`endif

    // Scan from the farthest offset back to ptr so the closest eligible lane wins.
    always_comb begin
        logic [1:0] idx;
        gnt          = ptr_q;
        any_eligible = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (eligible[idx]) begin
                gnt          = idx;
                any_eligible = 1'b1;
            end
        end
    end

    always_comb begin
        load     = !out_valid_q || bus.out_ready;
        accept   = rst_n && load && any_eligible;
        gnt_last = bus.in_last[gnt];
        bus.in_ready = accept ? (4'b0001 << gnt) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
            out_last_q  <= 1'b0;
        end else if (load) begin
            if (any_eligible) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.in_data[gnt*DATA_W +: DATA_W];
                out_sel_q   <= gnt;
                out_last_q  <= gnt_last;
                // In a locked packet gnt stays fixed, so ptr keeps its post-lock value.
                ptr_q       <= gnt + 2'd1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
        bus.out_sel   = out_sel_q;
        bus.out_last  = out_last_q;
    end

endmodule

// File: tb/tb_rr_mux4_collector.sv
// Self-checking bench for rr_mux4_collector: directed scenarios plus randomized traffic
// against a cycle-level reference model built from the arbitration rules.
module tb_rr_mux4_collector;

    localparam int unsigned DATA_W = 8;

    logic clk;
    logic rst_n;

    rr_mux4_collector_if #(.DATA_W(DATA_W)) bus ();

    rr_mux4_collector #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err;
    int n_checks;

    // Reference model state
    bit         m_ov;
    logic [7:0] m_od;
    int         m_os;
    bit         m_ol;
    int         m_ptr;
    bit         m_lock;
    int         m_lane;

    logic [3:0] acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ov   = 0;
        m_od   = 8'h00;
        m_os   = 0;
        m_ol   = 0;
        m_ptr  = 0;
        m_lock = 0;
        m_lane = 0;
    endtask

    // Check current DUT state against the model, then advance the model over the coming edge.
    task automatic tick();
        bit         load;
        bit         found;
        int         g;
        logic [3:0] exp_rdy;
        #2;
        if (!rst_n) model_reset();
        load  = !m_ov || bus.out_ready;
        found = 0;
        g     = 0;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (!found && bus.in_valid[i] && (!m_lock || i == m_lane)) begin
                found = 1;
                g     = i;
            end
        end
        exp_rdy = (rst_n && load && found) ? 4'(1 << g) : 4'b0000;
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check("out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("out_data", 32'(bus.out_data), 32'(m_od));
        check("out_sel", 32'(bus.out_sel), 32'(m_os));
        check("out_last", 32'(bus.out_last), 32'(m_ol));
        acc = bus.in_ready & bus.in_valid;
        if (rst_n && load) begin
            if (found) begin
                m_ov  = 1;
                m_od  = bus.in_data[g*8 +: 8];
                m_os  = g;
                m_ol  = bus.in_last[g];
                m_ptr = (g + 1) % 4;
`ifdef RR_MUX4_PKT_LOCK_EN
                if (!m_lock && !bus.in_last[g]) begin
                    m_lock = 1;
                    m_lane = g;
                end else if (m_lock && bus.in_last[g]) begin
                    m_lock = 0;
                end
`endif
            end else begin
                m_ov = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_lane(input int i, input bit v, input logic [7:0] d, input bit l);
        bus.in_valid[i]       = v;
        bus.in_data[i*8 +: 8] = d;
        bus.in_last[i]        = l;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int exp_lock[4];
    int beat0;

    initial begin
        n_err    = 0;
        n_checks = 0;
        acc      = 4'b0000;
        model_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 8'(8'h10 + i), 1'b1);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset with every lane offering
        @(negedge clk);
        tick();
        check("rst_ready", 32'(bus.in_ready), 32'h0);
        check("rst_data", 32'(bus.out_data), 32'h0);
        rst_n = 1'b1;

        // Round robin from ptr=0
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_sel", 32'(bus.out_sel), 32'(i % 4));
            check("rr_data", 32'(bus.out_data), 32'(8'h10 + i % 4));
        end

        // Single lane
        bus.in_valid = 4'b0000;
        set_lane(2, 1'b1, 8'hA5, 1'b1);
        #1 check("single_rdy", 32'(bus.in_ready), 32'b0100);
        tick();
        check("single_valid", 32'(bus.out_valid), 32'h1);
        check("single_sel", 32'(bus.out_sel), 32'h2);
        check("single_data", 32'(bus.out_data), 32'hA5);

        // Backpressure
        bus.in_valid = 4'b0000;
        set_lane(0, 1'b1, 8'h3C, 1'b1);
        tick();
        bus.out_ready = 1'b0;
        set_lane(0, 1'b1, 8'h40, 1'b1);
        set_lane(1, 1'b1, 8'h41, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_data", 32'(bus.out_data), 32'h3C);
            check("bp_ready", 32'(bus.in_ready), 32'h0);
        end
        bus.out_ready = 1'b1;
        #1 check("bp_resume_rdy", 32'(bus.in_ready), 32'b0010);
        tick();
        check("bp_next_sel", 32'(bus.out_sel), 32'h1);
        check("bp_next_data", 32'(bus.out_data), 32'h41);

        // Pointer wrap: ptr=2 after the lane-1 grant
        bus.in_valid = 4'b0000;
        set_lane(1, 1'b1, 8'h51, 1'b1);
        set_lane(3, 1'b1, 8'h53, 1'b1);
        tick();
        check("wrap_sel0", 32'(bus.out_sel), 32'h3);
        set_lane(3, 1'b1, 8'h63, 1'b1);
        tick();
        check("wrap_sel1", 32'(bus.out_sel), 32'h1);

        // Packet lock: lane 0 three-beat packet, lane 1 always valid
`ifdef RR_MUX4_PKT_LOCK_EN
        exp_lock[0] = 0; exp_lock[1] = 0; exp_lock[2] = 0; exp_lock[3] = 1;
`else
        exp_lock[0] = 0; exp_lock[1] = 1; exp_lock[2] = 0; exp_lock[3] = 1;
`endif
        bus.in_valid = 4'b0000;
        do_reset();
        beat0 = 0;
        set_lane(0, 1'b1, 8'hA0, 1'b0);
        set_lane(1, 1'b1, 8'h77, 1'b1);
        for (int j = 0; j < 4; j++) begin
            tick();
            check("lock_sel", 32'(bus.out_sel), 32'(exp_lock[j]));
            if (acc[0]) beat0++;
            set_lane(0, beat0 < 3, 8'(8'hA0 + beat0), beat0 == 2);
        end

        // Randomized traffic; offered beats stay stable until accepted
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!(bus.in_valid[i] && !acc[i])) begin
                    set_lane(i, ($urandom % 4) != 0, 8'($urandom), 1'($urandom));
                end
            end
            bus.out_ready = ($urandom % 3) != 0;
            if (c == 1500) begin
                rst_n = 1'b0;
                tick();
                check("midrst_valid", 32'(bus.out_valid), 32'h0);
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_mux4_collector.md
Name: rr_mux4_collector

Overview:
- 4-to-1 collector: the opposite end of the 1-to-4 demux path. It gathers beats from four lanes onto one stream.
- Each input lane uses a valid/ready handshake. A round-robin arbiter grants one lane per cycle.
- The granted beat is held in a single output register, tagged with its 2-bit source index.
- The output `out_sel` uses the same encoding as the demux `sel`, so a downstream demux can route a beat back by lane.

Parameters:
DATA_W, 8, width of each lane's data bus and of out_data

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  4  per-lane beat valid, bit i = lane i
in_data  input  4*DATA_W  lane i data at bits [i*DATA_W +: DATA_W]
in_last  input  4  per-lane end-of-packet marker (used only with macro)
in_ready  output  4  per-lane accept, one-hot or zero
out_valid  output  1  output register holds a beat
out_data  output  DATA_W  registered beat data
out_sel  output  2  source lane of held beat (00..11)
out_last  output  1  in_last of held beat
out_ready  input  1  downstream accept

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_sel=00, out_last=0.
  - Priority pointer ptr=0.
  - Lock state cleared to IDLE.
  - in_ready=0 while reset is asserted.
- Reset mid-operation discards any held beat. No partial state survives.
- Load enable: load = !out_valid || out_ready.
- Arbitration (combinational): the eligible set is in_valid, restricted by lock (see Optional Feature). Grant g = first eligible lane scanning ptr, ptr+1, ... modulo 4.
- in_ready[g] = load && any_eligible. All other in_ready bits are 0.
  - in_ready may depend combinationally on in_valid.
  - Upstream must not derive in_valid from in_ready.
- Accept edge: when in_valid[g] && in_ready[g] at a rising edge:
  - out_data <= lane g data, out_sel <= g, out_last <= in_last[g], out_valid <= 1.
  - ptr <= g+1, wrapping 3 -> 0.
- When load=1 and no lane is eligible: out_valid <= 0, and data/sel/last hold their previous values.
- When load=0 (out_valid && !out_ready): all output registers and ptr hold, and in_ready=0.
- Latency: 1 cycle from input accept to out_valid. Throughput: 1 beat/cycle when out_ready is held high.
- Simultaneous output drain and input accept in the same cycle: the new beat replaces the old one, so there is no bubble.
- Input rule: a lane holding in_valid=1 with in_ready=0 must keep its data/last stable. The collector never drops an offered beat.
- Fairness: a continuously valid lane waits at most 3 grants.

Optional Feature:
- Macro: RR_MUX4_PKT_LOCK_EN
- Defined: adds a two-state FSM, IDLE and LOCKED(L).
  - IDLE: all lanes are eligible. Accepting a beat with in_last=0 from lane g moves to LOCKED(g).
  - LOCKED(L): only lane L is eligible, even if other lanes are valid. ptr holds.
  - Accepting a beat from L with in_last=1 returns to IDLE with ptr <= L+1.
  - A single-beat packet (in_last=1 on the first beat) stays in IDLE.
- Not defined: no FSM, in_last is ignored for arbitration, and ptr advances on every accepted beat. out_last still forwards the granted lane's in_last.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 with all in_valid=1.
  - Required response: out_valid=0, out_data=0, out_sel=00, in_ready=0000. After release, the first grant goes to lane 0.
- Single lane:
  - Stimulus: lane 2 valid, data 0xA5, out_ready=1.
  - Required response: in_ready=0100 in cycle N. In cycle N+1, out_valid=1, out_data=0xA5, out_sel=10.
- Round robin:
  - Stimulus: all four lanes continuously valid with data 0x10/0x11/0x12/0x13, out_ready=1.
  - Required response: out_sel sequence 00,01,10,11,00 on consecutive cycles with matching data.
- Backpressure:
  - Stimulus: beat 0x3C held, out_ready=0 for 3 cycles, lanes 0 and 1 valid.
  - Required response: out_data stays 0x3C, in_ready=0000, ptr unchanged. On out_ready=1, the next beat loads the same cycle the old one drains.
- Pointer wrap:
  - Stimulus: ptr=2 (after a lane-1 grant), lanes 1 and 3 valid.
  - Required response: lane 3 is granted first (sel 11), then lane 1 (sel 01).
- Lock (macro defined):
  - Stimulus: lane 0 sends a 3-beat packet with last on beat 3, lane 1 valid throughout.
  - Required response: out_sel 00,00,00 then 01.
  - Without the macro, the same stimulus gives out_sel 00,01,00,01.
